// File: rtl/alu_arbiter_seq_pkg.sv
// alu_arbiter_seq shared definitions:
// datapath widths, opcode classes and FSM state encoding.
package alu_arbiter_seq_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W = 3;

    // opcodes at or above this value are arithmetic
    localparam logic [OP_W-1:0] ARITH_MIN = 3'b101;
    localparam logic [OP_W-1:0] LOGIC_NOP = 3'b000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } stateT;

endpackage

// File: rtl/alu_arbiter_seq_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter with lock.
// Priority moves only when a response completes.
module rr_arbiter2 (
    input  logic       iClock,
    input  logic       iResetn,
    input  logic       iEnable,
    input  logic [1:0] iValid,
    input  logic       iUpdate,
    input  logic       iUpdId,
    input  logic       iUpdLock,
    output logic [1:0] oGrant
);

    logic prio;
    logic other;
    logic lockHeld;

    assign other = ~prio;

    // a locked owner keeps priority, otherwise hand it to the peer
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            prio     <= 1'b0;
            lockHeld <= 1'b0;
        end else if (iUpdate) begin
            prio     <= iUpdLock ? iUpdId : ~iUpdId;
            lockHeld <= iUpdLock;
        end
    end

    // lock blocks the peer even while the owner is idle
    always_comb begin
        oGrant = 2'b00;
        if (iEnable) begin
            if (iValid[prio]) begin
                oGrant[prio] = 1'b1;
            end else if (!lockHeld && iValid[other]) begin
                oGrant[other] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter_seq.sv
// alu_arbiter_seq: shares one ALU between two requesters.
// One command in flight: IDLE, ISSUE, CAPTURE, RESP.
module alu_arbiter_seq #(
    parameter int DATA_W = alu_arbiter_seq_pkg::DATA_W,
    parameter int OP_W = alu_arbiter_seq_pkg::OP_W,
    parameter logic [OP_W-1:0] ARITH_MIN = alu_arbiter_seq_pkg::ARITH_MIN
) (
    input  logic              iClock,
    input  logic              iResetn,
    input  logic [1:0]        iReqValid,
    output logic [1:0]        oReqReady,
    input  logic [DATA_W-1:0] iReqA0,
    input  logic [DATA_W-1:0] iReqA1,
    input  logic [DATA_W-1:0] iReqB0,
    input  logic [DATA_W-1:0] iReqB1,
    input  logic [OP_W-1:0]   iReqOp0,
    input  logic [OP_W-1:0]   iReqOp1,
    input  logic [1:0]        iReqLock,
    output logic              oRspValid,
    input  logic              iRspReady,
    output logic              oRspId,
    output logic [DATA_W-1:0] oRspResult,
    output logic              oRspCarry,
    output logic              oRspZero,
    output logic [DATA_W-1:0] oAluA,
    output logic [DATA_W-1:0] oAluB,
    output logic [OP_W-1:0]   oAluOpcode,
    input  logic [DATA_W-1:0] iAluAcc,
    input  logic              iAluCarry,
    input  logic              iAluZero
);
    import alu_arbiter_seq_pkg::*;

    stateT state;
    stateT stateNext;

    logic [1:0] grant;
    logic accept;
    logic rspDone;

    logic [DATA_W-1:0] cmdA;
    logic [DATA_W-1:0] cmdB;
    logic [OP_W-1:0]   cmdOp;
    logic cmdId;
    logic cmdLock;

    assign accept    = |grant;
    assign rspDone   = (state == RESP) && iRspReady;
    assign oReqReady = grant;
    assign oRspValid = (state == RESP);

    rr_arbiter2 uArb (
        .iClock  (iClock),
        .iResetn (iResetn),
        .iEnable (state == IDLE),
        .iValid  (iReqValid),
        .iUpdate (rspDone),
        .iUpdId  (cmdId),
        .iUpdLock(cmdLock),
        .oGrant  (grant)
    );

    // state register
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // next state: fixed two-cycle ALU window, then wait for pickup
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (accept) stateNext = ISSUE;
            ISSUE:   stateNext = CAPTURE;
            CAPTURE: stateNext = RESP;
            RESP:    if (iRspReady) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // command register loads from the granted requester
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            cmdA    <= '0;
            cmdB    <= '0;
            cmdOp   <= '0;
            cmdId   <= 1'b0;
            cmdLock <= 1'b0;
        end else if (accept) begin
            unique case (1'b1)
                grant[0]: begin
                    cmdA    <= iReqA0;
                    cmdB    <= iReqB0;
                    cmdOp   <= iReqOp0;
                    cmdId   <= 1'b0;
                    cmdLock <= iReqLock[0];
                end
                grant[1]: begin
                    cmdA    <= iReqA1;
                    cmdB    <= iReqB1;
                    cmdOp   <= iReqOp1;
                    cmdId   <= 1'b1;
                    cmdLock <= iReqLock[1];
                end
                default: ;
            endcase
        end
    end

    // response register samples the ALU at the end of CAPTURE
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            oRspResult <= '0;
            oRspCarry  <= 1'b0;
            oRspZero   <= 1'b0;
            oRspId     <= 1'b0;
        end else if (state == CAPTURE) begin
            oRspResult <= iAluAcc;
            oRspZero   <= iAluZero;
            oRspCarry  <= (cmdOp >= ARITH_MIN) ? iAluCarry : 1'b0;
            oRspId     <= cmdId;
        end
    end

    // ALU sees the command only in ISSUE/CAPTURE, a NOP otherwise
    always_comb begin
        oAluA      = '0;
        oAluB      = '0;
        oAluOpcode = OP_W'(LOGIC_NOP);
        if (state == ISSUE || state == CAPTURE) begin
            oAluA      = cmdA;
            oAluB      = cmdB;
            oAluOpcode = cmdOp;
        end
    end

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// tb_alu_arbiter_seq: directed and random stimulus
// against a cycle-level reference model with a bench ALU.
module tb_alu_arbiter_seq;
    import alu_arbiter_seq_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [1:0] reqValid = 2'b00;
    logic [1:0] reqReady;
    logic [DATA_W-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic [OP_W-1:0] op0 = '0, op1 = '0;
    logic [1:0] reqLock = 2'b00;
    logic rspReady = 1'b1;
    logic rspValid, rspId, rspCarry, rspZero;
    logic [DATA_W-1:0] rspResult, aluA, aluB, aluAcc;
    logic [OP_W-1:0] aluOp;
    logic [DATA_W:0] aluFull;
    logic aluCarryQ = 1'b0;
    logic aluZeroQ = 1'b0;

    int checks = 0;
    int errors = 0;
    bit chkEn = 1'b1;

    always #5 clk = ~clk;

    alu_arbiter_seq dut (
        .iClock(clk), .iResetn(rstn),
        .iReqValid(reqValid), .oReqReady(reqReady),
        .iReqA0(a0), .iReqA1(a1), .iReqB0(b0), .iReqB1(b1),
        .iReqOp0(op0), .iReqOp1(op1), .iReqLock(reqLock),
        .oRspValid(rspValid), .iRspReady(rspReady),
        .oRspId(rspId), .oRspResult(rspResult),
        .oRspCarry(rspCarry), .oRspZero(rspZero),
        .oAluA(aluA), .oAluB(aluB), .oAluOpcode(aluOp),
        .iAluAcc(aluAcc), .iAluCarry(aluCarryQ), .iAluZero(aluZeroQ)
    );

    // bench ALU: {carry, result}
    function automatic logic [DATA_W:0] aluF(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [OP_W-1:0] op);
        case (op)
            3'b000: return {1'b0, a & b};
            3'b001: return {1'b0, a | b};
            3'b010: return {1'b0, a ^ b};
            3'b011: return {1'b0, ~a};
            3'b100: return {1'b0, a};
            3'b101: return {1'b0, a} + {1'b0, b};
            3'b110: return {1'b0, a} + {1'b0, ~b} + 17'd1;
            default: return {1'b0, a} + 17'd1;
        endcase
    endfunction

    assign aluFull = aluF(aluA, aluB, aluOp);
    assign aluAcc = aluFull[DATA_W-1:0];

    // carry is only written by arithmetic ops, logic ops leave it stale
    always @(posedge clk) begin
        if (aluOp >= 3'b101) aluCarryQ <= aluFull[DATA_W];
        aluZeroQ <= (aluFull[DATA_W-1:0] == '0);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] grantOf(input logic [1:0] v,
                                           input bit p, input bit l);
        if (v[p]) return p ? 2'b10 : 2'b01;
        if (!l && v[!p]) return p ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    // reference model: phase 0 idle, 1 issue, 2 capture, 3 response
    int mPhase = 0;
    bit mPrio = 1'b0;
    bit mLock = 1'b0;
    bit cId, cLock;
    logic [DATA_W-1:0] cA, cB;
    logic [OP_W-1:0] cOp;
    logic [DATA_W:0] cFull;
    logic [1:0] eg;

    always @(negedge clk) begin
        if (chkEn) begin
            if (!rstn) begin
                check("rst_ready", reqReady, 0);
                check("rst_valid", rspValid, 0);
                check("rst_result", rspResult, 0);
                check("rst_flags", {rspId, rspCarry, rspZero}, 0);
                check("rst_aluA", aluA, 0);
                check("rst_aluB", aluB, 0);
                check("rst_aluOp", aluOp, 0);
                mPhase = 0;
                mPrio = 1'b0;
                mLock = 1'b0;
            end else if (mPhase == 0) begin
                eg = grantOf(reqValid, mPrio, mLock);
                check("ready", reqReady, eg);
                check("idle_valid", rspValid, 0);
                check("idle_alu", {aluA, aluB}, 0);
                check("idle_op", aluOp, 0);
                if (eg != 2'b00) begin
                    cId = eg[1];
                    cA = cId ? a1 : a0;
                    cB = cId ? b1 : b0;
                    cOp = cId ? op1 : op0;
                    cLock = reqLock[cId];
                    cFull = aluF(cA, cB, cOp);
                    mPhase = 1;
                end
            end else if (mPhase < 3) begin
                check("busy_ready", reqReady, 0);
                check("busy_valid", rspValid, 0);
                check("alu_a", aluA, cA);
                check("alu_b", aluB, cB);
                check("alu_op", aluOp, cOp);
                mPhase++;
            end else begin
                check("rsp_ready", reqReady, 0);
                check("rsp_valid", rspValid, 1);
                check("rsp_id", rspId, cId);
                check("rsp_result", rspResult, cFull[DATA_W-1:0]);
                check("rsp_carry", rspCarry,
                      (cOp >= ARITH_MIN) ? cFull[DATA_W] : 1'b0);
                check("rsp_zero", rspZero, cFull[DATA_W-1:0] == '0);
                check("rsp_alu", {aluA, aluB}, 0);
                if (rspReady) begin
                    mPrio = cLock ? cId : !cId;
                    mLock = cLock;
                    mPhase = 0;
                end
            end
        end
    end

    task automatic setReq(input int id, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b,
                          input logic [OP_W-1:0] op, input bit lk);
        if (id == 0) begin
            a0 = a; b0 = b; op0 = op;
        end else begin
            a1 = a; b1 = b; op1 = op;
        end
        reqLock[id] = lk;
        reqValid[id] = 1'b1;
    endtask

    // waits for an accept, then withdraws that requester
    task automatic waitGrant(output int gid);
        gid = -1;
        for (int i = 0; i < 40 && gid < 0; i++) begin
            @(negedge clk);
            check("ready_onehot", reqReady == 2'b11, 0);
            if (|(reqValid & reqReady)) gid = reqReady[1] ? 1 : 0;
        end
        if (gid < 0) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: no accept within 40 cycles");
        end else begin
            @(posedge clk);
            #1;
            reqValid[gid] = 1'b0;
        end
    endtask

    task automatic waitRsp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rspValid && n < 40);
        if (!rspValid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: no response within 40 cycles");
        end
    endtask

    function automatic logic [DATA_W-1:0] rndOpnd();
        case ($urandom_range(0, 3))
            0: return 16'hFFFF;
            1: return 16'h0000;
            default: return DATA_W'($urandom);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int g, n;
    logic [1:0] acc;

    initial begin
        repeat (3) @(negedge clk);
        @(posedge clk); #3; rstn = 1'b1;
        @(posedge clk); #1;

        // both valid from reset: req0 first (add with carry out)
        setReq(0, 16'hFFFF, 16'h0001, 3'b101, 1'b0);
        setReq(1, 16'h0003, 16'h0004, 3'b101, 1'b0);
        waitGrant(g);
        check("g33_first", g, 0);
        setReq(0, 16'h00FF, 16'h0F00, 3'b010, 1'b0);
        waitRsp(n);
        check("r32_latency", n, 3);
        check("r32_result", rspResult, 16'h0000);
        check("r32_flags", {rspId, rspCarry, rspZero}, 3'b011);
        waitGrant(g);
        check("g33_second", g, 1);
        waitRsp(n);
        check("r33_result", rspResult, 16'h0007);
        check("r33_id", rspId, 1);
        waitGrant(g);
        check("g33_third", g, 0);
        waitRsp(n);
        check("r33_xor", rspResult, 16'h0FFF);

        // logic op after carry: stale ALU carry must be masked
        @(posedge clk); #1;
        setReq(0, 16'hFFFF, 16'h0001, 3'b101, 1'b0);
        waitGrant(g);
        waitRsp(n);
        check("r35_arith_carry", rspCarry, 1);
        @(posedge clk); #1;
        setReq(0, 16'hF0F0, 16'hFF00, 3'b000, 1'b0);
        waitGrant(g);
        check("g35", g, 0);
        waitRsp(n);
        check("r35_result", rspResult, 16'hF000);
        check("r35_carry", rspCarry, 0);

        // lock: req1 keeps the grant while req0 waits
        @(posedge clk); #1;
        setReq(0, 16'h0005, 16'h0006, 3'b101, 1'b0);
        setReq(1, 16'h1111, 16'h2222, 3'b101, 1'b1);
        waitGrant(g);
        check("g34_first", g, 1);
        waitRsp(n);
        check("r34_first", rspResult, 16'h3333);
        repeat (3) begin
            @(negedge clk);
            check("r34_locked", reqReady, 0);
        end
        @(posedge clk); #1;
        setReq(1, 16'h8000, 16'h8000, 3'b101, 1'b0);
        waitGrant(g);
        check("g34_second", g, 1);
        waitRsp(n);
        check("r34_second", {rspId, rspCarry, rspZero}, 3'b111);
        waitGrant(g);
        check("g34_third", g, 0);
        waitRsp(n);
        check("r34_third", rspResult, 16'h000B);

        // response back-pressure
        @(posedge clk); #1;
        rspReady = 1'b0;
        setReq(0, 16'h1234, 16'h0F0F, 3'b001, 1'b0);
        waitGrant(g);
        check("g36", g, 0);
        setReq(1, 16'h00AA, 16'h0000, 3'b100, 1'b0);
        waitRsp(n);
        check("r36_latency", n, 3);
        repeat (4) begin
            @(negedge clk);
            check("r36_valid", rspValid, 1);
            check("r36_result", rspResult, 16'h1F3F);
            check("r36_flags", {rspId, rspCarry, rspZero}, 3'b000);
            check("r36_ready", reqReady, 0);
        end
        @(posedge clk); #1;
        rspReady = 1'b1;
        waitGrant(g);
        check("g36_next", g, 1);
        waitRsp(n);
        check("r36_next", rspResult, 16'h00AA);

        // reset during CAPTURE discards the command
        @(posedge clk); #1;
        setReq(0, 16'h7FFF, 16'h0001, 3'b101, 1'b0);
        waitGrant(g);
        check("g37", g, 0);
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        check("r37_valid", rspValid, 0);
        check("r37_result", rspResult, 0);
        check("r37_id", rspId, 0);
        check("r37_aluA", aluA, 0);
        check("r37_aluB", aluB, 0);
        @(posedge clk); #3;
        rstn = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("r37_norsp", rspValid, 0);
        end
        @(posedge clk); #1;
        setReq(0, 16'h0001, 16'h0001, 3'b110, 1'b0);
        waitGrant(g);
        check("g37_after", g, 0);
        waitRsp(n);
        check("r37_after", {rspCarry, rspZero}, 2'b11);

        // random traffic, model checks every cycle
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            acc = reqValid & reqReady;
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (acc[i] || !reqValid[i]) begin
                    if ($urandom_range(0, 2) != 0)
                        setReq(i, rndOpnd(), rndOpnd(),
                               OP_W'($urandom_range(0, 7)),
                               $urandom_range(0, 3) == 0);
                    else
                        reqValid[i] = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    reqValid[i] = 1'b0;
                end
            end
            rspReady = ($urandom_range(0, 3) != 0);
        end

        @(posedge clk); #1;
        reqValid = 2'b00;
        rspReady = 1'b1;
        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
